traffic_phase_controller: RTL

TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

---
 rtl/traffic_phase_controller.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller
//   Main-road / side-road intersection sequencer with a pedestrian walk phase.
//   Main road rests on green and is released to yellow once its minimum green
//   has run and either a pedestrian press or a side-road vehicle is waiting.
//   After the all-red clearance the walk phase is served ahead of the side road.
//
// Ports
//   clk          single rising-edge clock
//   reset        asynchronous active-high reset
//   ped_btn      asynchronous pedestrian button (synchronized, rising edge used)
//   side_req     asynchronous side-road sensor level (synchronized)
//   walk_done    1-cycle done pulse from the external walk timer
//   main_lights  {red,yellow,green} main road, one-hot
//   side_lights  {red,yellow,green} side road, one-hot
//   walk_light   WALK lamp, high throughout WALK
//   walk_start   1-cycle pulse on the first WALK cycle
//   walk_enable  high throughout WALK
//   ped_pending  latched pedestrian request
//   state        current state encoding
//   fault        sticky walk-watchdog flag
//
// state          | meaning
// MAIN_GREEN  0  | main green, waits for min green and a request
// MAIN_YELLOW 1  | main yellow
// RED_TO_X    2  | all-red before walk or side green
// SIDE_GREEN  3  | side green, fixed length
// SIDE_YELLOW 4  | side yellow
// WALK        5  | pedestrian walk, ends on walk_done or watchdog
// RED_TO_MAIN 6  | all-red before main green
module traffic_phase_controller #(
  parameter int unsigned TICKS_PER_SEC  = 50_000_000,
  parameter int unsigned GREEN_MIN_SEC  = 10,
  parameter int unsigned YELLOW_SEC     = 3,
  parameter int unsigned ALL_RED_SEC    = 1,
  parameter int unsigned SIDE_GREEN_SEC = 8,
  parameter int unsigned WALK_MAX_SEC   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_btn,
  input  logic       side_req,
  input  logic       walk_done,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_light,
  output logic       walk_start,
  output logic       walk_enable,
  output logic       ped_pending,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    ST_MAIN_GREEN  = 3'd0,
    ST_MAIN_YELLOW = 3'd1,
    ST_RED_TO_X    = 3'd2,
    ST_SIDE_GREEN  = 3'd3,
    ST_SIDE_YELLOW = 3'd4,
    ST_WALK        = 3'd5,
    ST_RED_TO_MAIN = 3'd6,
    ST_ILLEGAL     = 3'd7
  } state_e;

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned SW = 16;

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] SEC_MAX     = {SW{1'b1}};
  localparam logic [SW-1:0] GREEN_MIN   = SW'(GREEN_MIN_SEC);
  localparam logic [SW-1:0] GREEN_LAST  = SW'(GREEN_MIN_SEC - 1);
  localparam logic [SW-1:0] YELLOW_LAST = SW'(YELLOW_SEC - 1);
  localparam logic [SW-1:0] ALLRED_LAST = SW'(ALL_RED_SEC - 1);
  localparam logic [SW-1:0] SIDEG_LAST  = SW'(SIDE_GREEN_SEC - 1);
  localparam logic [SW-1:0] WALK_LAST   = SW'(WALK_MAX_SEC - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          ped_meta_q, ped_sync_q, ped_prev_q;
  logic          side_meta_q, side_sync_q;
  logic          ped_pending_q, ped_pending_d;
  logic          fault_q, fault_set;
  logic [2:0]    main_q, main_d, side_q, side_d;
  logic          walk_q, walk_start_q, walk_entry;
  logic          tick_wrap, green_min_met, ped_rise;

  assign tick_wrap = (tick_q == TICK_LAST);
  assign ped_rise  = ped_sync_q & ~ped_prev_q;
  // True on the last cycle of the minimum green and on every cycle after it.
  assign green_min_met = (sec_q >= GREEN_MIN) || (tick_wrap && (sec_q == GREEN_LAST));

  always_comb begin
    state_d   = state_q;
    fault_set = 1'b0;
    case (state_q)
      ST_MAIN_GREEN:  if (green_min_met && (ped_pending_q || side_sync_q)) state_d = ST_MAIN_YELLOW;
      ST_MAIN_YELLOW: if (tick_wrap && sec_q == YELLOW_LAST) state_d = ST_RED_TO_X;
      ST_RED_TO_X:    if (tick_wrap && sec_q == ALLRED_LAST)
                        state_d = ped_pending_q ? ST_WALK : ST_SIDE_GREEN;
      ST_SIDE_GREEN:  if (tick_wrap && sec_q == SIDEG_LAST) state_d = ST_SIDE_YELLOW;
      ST_SIDE_YELLOW: if (tick_wrap && sec_q == YELLOW_LAST) state_d = ST_RED_TO_MAIN;
      ST_WALK: begin
        // A done pulse on the watchdog's last cycle still counts as a clean exit.
        if (walk_done) begin
          state_d = ST_RED_TO_MAIN;
        end else if (tick_wrap && sec_q == WALK_LAST) begin
          state_d   = ST_RED_TO_MAIN;
          fault_set = 1'b1;
        end
      end
      ST_RED_TO_MAIN: if (tick_wrap && sec_q == ALLRED_LAST) state_d = ST_MAIN_GREEN;
      default:        state_d = ST_MAIN_GREEN;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      tick_d = '0;
      sec_d  = '0;
    end else if (tick_wrap) begin
      tick_d = '0;
      sec_d  = (sec_q == SEC_MAX) ? sec_q : sec_q + 1'b1;
    end else begin
      tick_d = tick_q + 1'b1;
      sec_d  = sec_q;
    end
  end

  assign walk_entry = (state_d == ST_WALK) && (state_q != ST_WALK);

  always_comb begin
    ped_pending_d = ped_pending_q;
    if (ped_rise && state_q != ST_WALK) ped_pending_d = 1'b1;
    if (walk_entry) ped_pending_d = 1'b0;
  end

  // Lamps are decoded from the next state so they change on the same edge as state.
  always_comb begin
    main_d = LAMP_RED;
    side_d = LAMP_RED;
    case (state_d)
      ST_MAIN_GREEN:  main_d = LAMP_GREEN;
      ST_MAIN_YELLOW: main_d = LAMP_YELLOW;
      ST_SIDE_GREEN:  side_d = LAMP_GREEN;
      ST_SIDE_YELLOW: side_d = LAMP_YELLOW;
      default: begin
        main_d = LAMP_RED;
        side_d = LAMP_RED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_MAIN_GREEN;
      tick_q        <= '0;
      sec_q         <= '0;
      ped_meta_q    <= 1'b0;
      ped_sync_q    <= 1'b0;
      ped_prev_q    <= 1'b0;
      side_meta_q   <= 1'b0;
      side_sync_q   <= 1'b0;
      ped_pending_q <= 1'b0;
      fault_q       <= 1'b0;
      main_q        <= LAMP_GREEN;
      side_q        <= LAMP_RED;
      walk_q        <= 1'b0;
      walk_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      sec_q         <= sec_d;
      ped_meta_q    <= ped_btn;
      ped_sync_q    <= ped_meta_q;
      ped_prev_q    <= ped_sync_q;
      side_meta_q   <= side_req;
      side_sync_q   <= side_meta_q;
      ped_pending_q <= ped_pending_d;
      fault_q       <= fault_q | fault_set;
      main_q        <= main_d;
      side_q        <= side_d;
      walk_q        <= (state_d == ST_WALK);
      walk_start_q  <= walk_entry;
    end
  end

  assign state       = state_q;
  assign main_lights = main_q;
  assign side_lights = side_q;
  assign walk_light  = walk_q;
  assign walk_enable = walk_q;
  assign walk_start  = walk_start_q;
  assign ped_pending = ped_pending_q;
  assign fault       = fault_q;

endmodule
